hazard_ctrl_unit: RTL and testbench
===================================

// Module: hazard_ctrl_unit
// PURPOSE
//  Pipeline hazard controller for the 5-stage core (IF/ID/EX/MEM/WB), generalising the load-use detector.
//  - Combinational EX-operand forwarding selects.
//  - Load-use bubble insertion.
//  - Taken-branch flush.
//  - Multi-cycle data-memory wait, frozen by a counter FSM.
//  - Saturating stall-cycle performance counter.
//  Drives the enables/clears of the PC, IF/ID, ID/EX and EX/MEM registers.
// PARAMETERS
//  RAW     5   register-address width
//  MEM_LAT 1   data-memory access latency in cycles (>=1); 1 = no wait state
//  CNT_W   16  width of the stall_cycles counter
// PORTS
//  clk           in  1    clock
//  rst_n         in  1    asynchronous active-low reset
//  de_rs1/de_rs2 in  RAW  ID-stage source registers
//  de_rs1_used/de_rs2_used in 1  ID instruction actually reads rs1/rs2
//  ex_rs1/ex_rs2 in  RAW  EX-stage source registers
//  ex_rd         in  RAW  EX-stage destination register
//  ex_dmrd       in  1    EX instruction is a load
//  ex_br_taken   in  1    EX resolved a taken branch/jump
//  mem_rd        in  RAW  MEM-stage destination register
//  mem_regwr     in  1    MEM instruction writes the register file
//  mem_dmacc     in  1    MEM instruction accesses data memory (load or store)
//  wb_rd         in  RAW  WB-stage destination register
//  wb_regwr      in  1    WB instruction writes the register file
//  pc_en/fd_en/de_en/em_en  out 1  register enables (1 = advance)
//  fd_clr/de_clr out 1    synchronous bubble insert into IF/ID, ID/EX
//  fwd_a/fwd_b   out 2    EX operand select: 00 regfile, 10 from MEM, 01 from WB
//  stall_cycles  out CNT_W  cycles with pc_en==0 since reset, saturating
// BEHAVIOUR
//  - Register x0 never matches in any comparison (rd==0 is never a hazard or forward source).
//  - Forwarding (comb, always active):
//    - fwd_a=10 if mem_regwr && mem_rd==ex_rs1 && mem_rd!=0;
//    - else 01 if wb_regwr && wb_rd==ex_rs1 && wb_rd!=0;
//    - else 00.
//    - fwd_b likewise with ex_rs2.
//  - load_use = ex_dmrd && ex_rd!=0 && ((de_rs1_used && de_rs1==ex_rd) || (de_rs2_used && de_rs2==ex_rd)).
//  - FSM states: RUN, MEM_WAIT. State and wait counter are registered; outputs are a comb function of state+inputs.
//  - RUN, default: all enables 1, clears 0.
//  - RUN, load_use: pc_en=fd_en=0, de_clr=1 (one bubble); resolves next cycle when the load reaches MEM.
//  - RUN, ex_br_taken: fd_clr=de_clr=1, pc_en=1. Overrides load_use (the stalled instruction is squashed anyway).
//  - RUN, mem_dmacc && MEM_LAT>1: enter MEM_WAIT, wait_cnt<=MEM_LAT-2.
//    - This cycle and every MEM_WAIT cycle: pc_en=fd_en=de_en=em_en=0, clears 0.
//    - Frozen stages hold, so load_use and ex_br_taken are re-evaluated after release.
//  - MEM_WAIT: wait_cnt decrements. At wait_cnt==0 return to RUN; enables released next cycle.
//  - A mem_dmacc present on the first RUN cycle after release is a new access and re-enters MEM_WAIT.
//  - Total freeze per access = MEM_LAT-1 cycles.
//  - MEM_LAT==1: MEM_WAIT unreachable.
//  - stall_cycles += 1 every cycle pc_en==0; holds at 2^CNT_W-1.
//  - Reset (async, any time including mid-MEM_WAIT): state=RUN, wait_cnt=0, stall_cycles=0.
//    - Outputs immediately: enables 1, clears 0; fwd_* follow inputs.
// STRUCTURE
//  - Shared package core_pkg: fwd_sel_e {FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10}; hz_state_e {HZ_RUN, HZ_MEM_WAIT}.
//  - Sub-module fwd_sel: pure comb, one per operand, instantiated twice.
//  - FSM, counter and load-use logic stay in hazard_ctrl_unit.
// TESTING
//  1. Forwarding (mem_regwr=1, mem_rd=5, wb_regwr=1, wb_rd=5, ex_rs1=5) -> fwd_a=10; mem_rd=0 -> fwd_a=01; ex_rs2=7 -> fwd_b=00.
//  2. Load-use bubble (ex_dmrd=1, ex_rd=3, de_rs2=3, de_rs2_used=1) -> pc_en=fd_en=0, de_clr=1 for 1 cycle; stall_cycles=1.
//  3. No hazard on x0/unused source (ex_rd=0 with de_rs1=de_rs2=0, or match only on an unused rs) -> no stall, no clear.
//  4. Branch priority (ex_br_taken=1 together with load_use) -> fd_clr=de_clr=1, pc_en=1.
//  5. Memory wait, MEM_LAT=4 (mem_dmacc=1 one access) -> all enables 0 for exactly 3 cycles, then 1; stall_cycles=3.
//  6. Reset/saturation (rst_n low during 2nd MEM_WAIT cycle) -> enables 1, counter 0 at once; with CNT_W=2, 5 stalls -> stall_cycles=3.

Source files
------------

// File: rtl/core_pkg.sv
// Shared pipeline-control types: forwarding selects, hazard FSM states and
// the bundle of stage enables/clears the hazard unit drives.
package core_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        HZ_RUN      = 1'b0,
        HZ_MEM_WAIT = 1'b1
    } hz_state_e;

    typedef struct packed {
        logic pc_en;
        logic fd_en;
        logic de_en;
        logic em_en;
        logic fd_clr;
        logic de_clr;
    } pipe_ctl_t;

    localparam pipe_ctl_t CTL_RUN    = '{pc_en: 1'b1, fd_en: 1'b1, de_en: 1'b1, em_en: 1'b1, fd_clr: 1'b0, de_clr: 1'b0};
    localparam pipe_ctl_t CTL_BUBBLE = '{pc_en: 1'b0, fd_en: 1'b0, de_en: 1'b1, em_en: 1'b1, fd_clr: 1'b0, de_clr: 1'b1};
    localparam pipe_ctl_t CTL_FLUSH  = '{pc_en: 1'b1, fd_en: 1'b1, de_en: 1'b1, em_en: 1'b1, fd_clr: 1'b1, de_clr: 1'b1};
    localparam pipe_ctl_t CTL_FREEZE = '{pc_en: 1'b0, fd_en: 1'b0, de_en: 1'b0, em_en: 1'b0, fd_clr: 1'b0, de_clr: 1'b0};

endpackage

// File: rtl/hazard_ctrl_unit_fwd_sel.sv
// EX-operand bypass select for one source register; MEM result wins over WB,
// and x0 is never a forwarding source.
module fwd_sel
    import core_pkg::*;
#(
    parameter int RAW = 5
) (
    input  logic [RAW-1:0] ex_rs,
    input  logic [RAW-1:0] mem_rd,
    input  logic           mem_regwr,
    input  logic [RAW-1:0] wb_rd,
    input  logic           wb_regwr,
    output fwd_sel_e       sel
);

    // Priority bypass select: youngest producer first
    always_comb begin
        sel = FWD_RF;
        if (mem_regwr && (mem_rd == ex_rs) && (mem_rd != {RAW{1'b0}})) begin
            sel = FWD_MEM;
        end else if (wb_regwr && (wb_rd == ex_rs) && (wb_rd != {RAW{1'b0}})) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: operand forwarding, load-use bubble, branch flush,
// data-memory wait freeze and a saturating stall-cycle counter.
module hazard_ctrl_unit
    import core_pkg::*;
#(
    parameter int RAW     = 5,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [RAW-1:0]   de_rs1,
    input  logic [RAW-1:0]   de_rs2,
    input  logic             de_rs1_used,
    input  logic             de_rs2_used,
    input  logic [RAW-1:0]   ex_rs1,
    input  logic [RAW-1:0]   ex_rs2,
    input  logic [RAW-1:0]   ex_rd,
    input  logic             ex_dmrd,
    input  logic             ex_br_taken,
    input  logic [RAW-1:0]   mem_rd,
    input  logic             mem_regwr,
    input  logic             mem_dmacc,
    input  logic [RAW-1:0]   wb_rd,
    input  logic             wb_regwr,
    output logic             pc_en,
    output logic             fd_en,
    output logic             de_en,
    output logic             em_en,
    output logic             fd_clr,
    output logic             de_clr,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int             WCW         = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
    localparam logic [WCW-1:0] WAIT_INIT   = WCW'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);
    localparam logic           MEM_WAIT_EN = (MEM_LAT > 1);

    hz_state_e        state_r;
    hz_state_e        state_nxt_s;
    logic [WCW-1:0]   wait_cnt_r;
    logic [WCW-1:0]   wait_cnt_nxt_s;
    logic [CNT_W-1:0] stall_cycles_r;
    logic             load_use_s;
    pipe_ctl_t        run_ctl_s;
    pipe_ctl_t        ctl_s;
    fwd_sel_e         fwd_a_s;
    fwd_sel_e         fwd_b_s;

    fwd_sel #(.RAW(RAW)) u_fwd_a (
        .ex_rs     (ex_rs1),
        .mem_rd    (mem_rd),
        .mem_regwr (mem_regwr),
        .wb_rd     (wb_rd),
        .wb_regwr  (wb_regwr),
        .sel       (fwd_a_s)
    );

    fwd_sel #(.RAW(RAW)) u_fwd_b (
        .ex_rs     (ex_rs2),
        .mem_rd    (mem_rd),
        .mem_regwr (mem_regwr),
        .wb_rd     (wb_rd),
        .wb_regwr  (wb_regwr),
        .sel       (fwd_b_s)
    );

    assign load_use_s = ex_dmrd && (ex_rd != {RAW{1'b0}}) &&
                        ((de_rs1_used && (de_rs1 == ex_rd)) ||
                         (de_rs2_used && (de_rs2 == ex_rd)));

    // Unfrozen pipeline control: a taken branch squashes the stalled instruction anyway
    always_comb begin
        run_ctl_s = CTL_RUN;
        if (ex_br_taken) begin
            run_ctl_s = CTL_FLUSH;
        end else if (load_use_s) begin
            run_ctl_s = CTL_BUBBLE;
        end else begin
            run_ctl_s = CTL_RUN;
        end
    end

    // Wait FSM next state and stage control; the wait_cnt==0 cycle already releases the pipe
    always_comb begin
        state_nxt_s    = state_r;
        wait_cnt_nxt_s = wait_cnt_r;
        ctl_s          = CTL_RUN;
        case (state_r)
            HZ_RUN: begin
                if (mem_dmacc && MEM_WAIT_EN) begin
                    ctl_s          = CTL_FREEZE;
                    state_nxt_s    = HZ_MEM_WAIT;
                    wait_cnt_nxt_s = WAIT_INIT;
                end else begin
                    ctl_s = run_ctl_s;
                end
            end
            HZ_MEM_WAIT: begin
                if (wait_cnt_r == {WCW{1'b0}}) begin
                    ctl_s       = run_ctl_s;
                    state_nxt_s = HZ_RUN;
                end else begin
                    ctl_s          = CTL_FREEZE;
                    wait_cnt_nxt_s = wait_cnt_r - WCW'(1);
                end
            end
            default: begin
                ctl_s          = CTL_RUN;
                state_nxt_s    = HZ_RUN;
                wait_cnt_nxt_s = {WCW{1'b0}};
            end
        endcase
    end

    // FSM state and wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= HZ_RUN;
            wait_cnt_r <= {WCW{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
        end
    end

    // Saturating count of cycles in which the PC did not advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_r <= {CNT_W{1'b0}};
        end else if (!ctl_s.pc_en && (stall_cycles_r != {CNT_W{1'b1}})) begin
            stall_cycles_r <= stall_cycles_r + CNT_W'(1);
        end else begin
            stall_cycles_r <= stall_cycles_r;
        end
    end

    assign pc_en        = ctl_s.pc_en;
    assign fd_en        = ctl_s.fd_en;
    assign de_en        = ctl_s.de_en;
    assign em_en        = ctl_s.em_en;
    assign fd_clr       = ctl_s.fd_clr;
    assign de_clr       = ctl_s.de_clr;
    assign fwd_a        = fwd_a_s;
    assign fwd_b        = fwd_b_s;
    assign stall_cycles = stall_cycles_r;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: a wait-state instance (MEM_LAT=4) and a
// narrow-counter instance (MEM_LAT=1, CNT_W=2) share one stimulus.
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] de_rs1, de_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic       de_rs1_used, de_rs2_used, ex_dmrd, ex_br_taken;
    logic       mem_regwr, mem_dmacc, wb_regwr;

    logic        pc_en, fd_en, de_en, em_en, fd_clr, de_clr;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cycles;
    logic        pc_en2, fd_en2, de_en2, em_en2, fd_clr2, de_clr2;
    logic [1:0]  fwd_a2, fwd_b2;
    logic [1:0]  stall_cycles2;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic [4:0] de_rs1;
        logic [4:0] de_rs2;
        logic       de_rs1_used;
        logic       de_rs2_used;
        logic [4:0] ex_rs1;
        logic [4:0] ex_rs2;
        logic [4:0] ex_rd;
        logic       ex_dmrd;
        logic       ex_br_taken;
        logic [4:0] mem_rd;
        logic       mem_regwr;
        logic [4:0] wb_rd;
        logic       wb_regwr;
        logic [1:0] exp_fa;
        logic [1:0] exp_fb;
        logic [5:0] exp_ctl;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.RAW(5), .MEM_LAT(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .de_rs1(de_rs1), .de_rs2(de_rs2), .de_rs1_used(de_rs1_used), .de_rs2_used(de_rs2_used),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_dmrd(ex_dmrd), .ex_br_taken(ex_br_taken),
        .mem_rd(mem_rd), .mem_regwr(mem_regwr), .mem_dmacc(mem_dmacc),
        .wb_rd(wb_rd), .wb_regwr(wb_regwr),
        .pc_en(pc_en), .fd_en(fd_en), .de_en(de_en), .em_en(em_en),
        .fd_clr(fd_clr), .de_clr(de_clr), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cycles(stall_cycles)
    );

    hazard_ctrl_unit #(.RAW(5), .MEM_LAT(1), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .de_rs1(de_rs1), .de_rs2(de_rs2), .de_rs1_used(de_rs1_used), .de_rs2_used(de_rs2_used),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_dmrd(ex_dmrd), .ex_br_taken(ex_br_taken),
        .mem_rd(mem_rd), .mem_regwr(mem_regwr), .mem_dmacc(mem_dmacc),
        .wb_rd(wb_rd), .wb_regwr(wb_regwr),
        .pc_en(pc_en2), .fd_en(fd_en2), .de_en(de_en2), .em_en(em_en2),
        .fd_clr(fd_clr2), .de_clr(de_clr2), .fwd_a(fwd_a2), .fwd_b(fwd_b2),
        .stall_cycles(stall_cycles2)
    );

    function automatic logic [5:0] ctl1();
        return {pc_en, fd_en, de_en, em_en, fd_clr, de_clr};
    endfunction

    function automatic logic [5:0] ctl2();
        return {pc_en2, fd_en2, de_en2, em_en2, fd_clr2, de_clr2};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        de_rs1 = 5'd0; de_rs2 = 5'd0; de_rs1_used = 1'b0; de_rs2_used = 1'b0;
        ex_rs1 = 5'd0; ex_rs2 = 5'd0; ex_rd = 5'd0; ex_dmrd = 1'b0; ex_br_taken = 1'b0;
        mem_rd = 5'd0; mem_regwr = 1'b0; mem_dmacc = 1'b0; wb_rd = 5'd0; wb_regwr = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        de_rs1 = v.de_rs1; de_rs2 = v.de_rs2; de_rs1_used = v.de_rs1_used; de_rs2_used = v.de_rs2_used;
        ex_rs1 = v.ex_rs1; ex_rs2 = v.ex_rs2; ex_rd = v.ex_rd; ex_dmrd = v.ex_dmrd; ex_br_taken = v.ex_br_taken;
        mem_rd = v.mem_rd; mem_regwr = v.mem_regwr; wb_rd = v.wb_rd; wb_regwr = v.wb_regwr;
        mem_dmacc = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // ctl = {pc_en, fd_en, de_en, em_en, fd_clr, de_clr}
        vecs[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 5'd7, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 2'b10, 2'b00, 6'b111100};
        vecs[1]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 5'd7, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b1, 2'b01, 2'b00, 6'b111100};
        vecs[2]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 5'd9, 1'b1, 2'b00, 2'b10, 6'b111100};
        vecs[3]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 5'd5, 1'b0, 2'b00, 2'b00, 6'b111100};
        vecs[4]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 5'd5, 1'b1, 2'b01, 2'b01, 6'b111100};
        vecs[5]  = '{5'd0, 5'd3, 1'b0, 1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 6'b001101};
        vecs[6]  = '{5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 6'b001101};
        vecs[7]  = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 6'b111100};
        vecs[8]  = '{5'd3, 5'd4, 1'b0, 1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 6'b111100};
        vecs[9]  = '{5'd3, 5'd3, 1'b1, 1'b1, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 6'b111100};
        vecs[10] = '{5'd0, 5'd3, 1'b0, 1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 6'b111111};
        vecs[11] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 6'b111111};
        vecs[12] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 2'b00, 2'b00, 6'b111100};

        // Reset state while rst_n is held low
        idle();
        #1;
        chk("reset_ctl", 32'(ctl1()), 32'h3C);
        chk("reset_ctl2", 32'(ctl2()), 32'h3C);
        chk("reset_stall", 32'(stall_cycles), 32'd0);
        chk("reset_stall2", 32'(stall_cycles2), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d_fwd_a", i), 32'(fwd_a), 32'(vecs[i].exp_fa));
            chk($sformatf("v%0d_fwd_b", i), 32'(fwd_b), 32'(vecs[i].exp_fb));
            chk($sformatf("v%0d_ctl", i), 32'(ctl1()), 32'(vecs[i].exp_ctl));
            chk($sformatf("v%0d_ctl2", i), 32'(ctl2()), 32'(vecs[i].exp_ctl));
        end

        // Load-use: exactly one bubble cycle, one stall counted
        do_reset();
        drive(vecs[5]);
        #1;
        chk("lu_bubble", 32'(ctl1()), 32'h0D);
        @(negedge clk);
        idle();
        #1;
        chk("lu_release", 32'(ctl1()), 32'h3C);
        chk("lu_stall", 32'(stall_cycles), 32'd1);

        // Memory wait, MEM_LAT=4: three frozen cycles, MEM_LAT=1 never freezes
        do_reset();
        mem_dmacc = 1'b1;
        #1;
        chk("mw_c0", 32'(ctl1()), 32'h00);
        chk("mw_lat1_ctl", 32'(ctl2()), 32'h3C);
        @(negedge clk);
        mem_dmacc = 1'b0;
        #1;
        chk("mw_c1", 32'(ctl1()), 32'h00);
        @(negedge clk);
        #1;
        chk("mw_c2", 32'(ctl1()), 32'h00);
        @(negedge clk);
        #1;
        chk("mw_c3_release", 32'(ctl1()), 32'h3C);
        @(negedge clk);
        #1;
        chk("mw_c4_run", 32'(ctl1()), 32'h3C);
        chk("mw_stall", 32'(stall_cycles), 32'd3);
        chk("mw_lat1_stall", 32'(stall_cycles2), 32'd0);

        // Async reset during the second MEM_WAIT cycle
        do_reset();
        mem_dmacc = 1'b1;
        @(negedge clk);
        mem_dmacc = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_mw_frozen", 32'(ctl1()), 32'h00);
        chk("rst_mw_stall_pre", 32'(stall_cycles), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("rst_mw_ctl", 32'(ctl1()), 32'h3C);
        chk("rst_mw_stall", 32'(stall_cycles), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_mw_after", 32'(ctl1()), 32'h3C);
        chk("rst_mw_stall_after", 32'(stall_cycles), 32'd0);

        // Saturation: five stalled cycles on a 2-bit counter
        do_reset();
        drive(vecs[5]);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #1;
        chk("sat_stall2", 32'(stall_cycles2), 32'd3);
        chk("sat_stall16", 32'(stall_cycles), 32'd5);
        idle();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
